// File: rtl/sram_image_server.sv
// sram_image_server: serves whole 512-byte (2^SECTOR_AW) sectors between a host sector buffer
// and a byte-wide SRAM that holds one disk image per virtual drive.
//
// Ports:
//   clk_i, reset_i            sole clock; synchronous active-high reset
//   sd_lba                    sector number of the pending request
//   sd_rd / sd_wr             per-drive level read / write requests
//   sd_ack                    per-drive acknowledge, high for the whole transfer
//   sd_buff_addr/dout/din/wr  host sector buffer port (din valid 1 cycle after addr)
//   sram_addr_o/data_i/data_o/we_o  SRAM port (data_i valid SRAM_LAT cycles after addr)
//   busy_o                    high whenever a transfer is in progress
//   err_o                     one-cycle pulse when the latched LBA is outside the image
module sram_image_server #(
    parameter int unsigned NUM_DRIVES = 2,
    parameter int unsigned SRAM_AW    = 19,
    parameter int unsigned SECTOR_AW  = 9,
    parameter int unsigned SRAM_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [31:0]           sd_lba,
    input  logic [NUM_DRIVES-1:0] sd_rd,
    input  logic [NUM_DRIVES-1:0] sd_wr,
    output logic [NUM_DRIVES-1:0] sd_ack,
    output logic [SECTOR_AW-1:0]  sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    input  logic [7:0]            sd_buff_din,
    output logic                  sd_buff_wr,
    output logic [SRAM_AW-1:0]    sram_addr_o,
    input  logic [7:0]            sram_data_i,
    output logic [7:0]            sram_data_o,
    output logic                  sram_we_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned DW    = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 0;
    localparam int unsigned DW_W  = (DW > 0) ? DW : 1;
    localparam int unsigned LBA_W = SRAM_AW - SECTOR_AW - DW;
    localparam logic [SECTOR_AW-1:0] LAST_BYTE = '1;

    typedef enum logic [3:0] {
        StIdle, StStart, StRdAddr, StRdWait, StRdPut, StWrAddr, StWrWait, StWrPut, StDone
    } state_t;

    state_t                state_q, state_d;
    logic [DW_W-1:0]       drive_q, drive_d;
    logic                  is_rd_q, is_rd_d;
    logic [31:0]           lba_q, lba_d;
    logic [SECTOR_AW-1:0]  byte_q, byte_d;
    logic [2:0]            wait_q, wait_d;
    logic [NUM_DRIVES-1:0] ack_q, ack_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            wdata_q, wdata_d;

    logic                  req_any;
    logic                  req_rd;
    logic [DW_W-1:0]       req_sel;
    logic                  range_err;

    // Any LBA bit above the image's sector field means the sector is not in SRAM.
    assign range_err = (lba_q >> LBA_W) != 32'd0;

    // Lowest-numbered requesting drive wins; read beats write on the same drive.
    always_comb begin
        req_any = 1'b0;
        req_rd  = 1'b0;
        req_sel = '0;
        for (int i = int'(NUM_DRIVES) - 1; i >= 0; i--) begin
            if (sd_rd[i] || sd_wr[i]) begin
                req_any = 1'b1;
                req_rd  = sd_rd[i];
                req_sel = DW_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drive_d = drive_q;
        is_rd_d = is_rd_q;
        lba_d   = lba_q;
        byte_d  = byte_q;
        wait_d  = wait_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = StStart;
                    drive_d = req_sel;
                    is_rd_d = req_rd;
                    lba_d   = sd_lba;
                    byte_d  = '0;
                    for (int i = 0; i < int'(NUM_DRIVES); i++) begin
                        ack_d[i] = (req_sel == DW_W'(i));
                    end
                end
            end
            StStart:  state_d = is_rd_q ? StRdAddr : StWrAddr;
            StRdAddr: begin
                state_d = StRdWait;
                wait_d  = '0;
            end
            StRdWait: begin
                if (wait_q == 3'(SRAM_LAT - 1)) begin
                    state_d = StRdPut;
                    dout_d  = range_err ? 8'h00 : sram_data_i;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            StWrAddr: state_d = StWrWait;
            StWrWait: begin
                state_d = StWrPut;
                wdata_d = sd_buff_din;
            end
            StRdPut, StWrPut: begin
                if (byte_q == LAST_BYTE) begin
                    state_d = StDone;
                    ack_d   = '0;
                end else begin
                    byte_d  = byte_q + 1'b1;
                    state_d = is_rd_q ? StRdAddr : StWrAddr;
                end
            end
            StDone: begin
                state_d = StIdle;
                ack_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            drive_q <= '0;
            is_rd_q <= 1'b0;
            lba_q   <= '0;
            byte_q  <= '0;
            wait_q  <= '0;
            ack_q   <= '0;
            dout_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            drive_q <= drive_d;
            is_rd_q <= is_rd_d;
            lba_q   <= lba_d;
            byte_q  <= byte_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            wdata_q <= wdata_d;
        end
    end

    // Address is built only from registers, so it is stable from ADDR through PUT.
    if (DW > 0) begin : g_drv_addr
        assign sram_addr_o = {drive_q[DW-1:0], lba_q[LBA_W-1:0], byte_q};
    end else begin : g_one_drive_addr
        assign sram_addr_o = {lba_q[LBA_W-1:0], byte_q};
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = byte_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = (state_q == StRdPut);
    assign sram_data_o  = wdata_q;
    assign sram_we_o    = (state_q == StWrPut) && !range_err;
    assign busy_o       = (state_q != StIdle);
    assign err_o        = (state_q == StStart) && range_err;

endmodule
